// File: rtl/decade_counter_ctrl_pkg.sv
// Shared types and constants for the two-digit BCD run/pause/clear counter.
// Segment patterns are g..a active-high in bits 6:0; bits 8:7 stay 0.
package decade_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int NUM_KEYS  = 2;
  localparam int KEY_START = 0;
  localparam int KEY_CLEAR = 1;

  localparam logic [8:0] SEG_0     = 9'h03F;
  localparam logic [8:0] SEG_1     = 9'h006;
  localparam logic [8:0] SEG_2     = 9'h05B;
  localparam logic [8:0] SEG_3     = 9'h04F;
  localparam logic [8:0] SEG_4     = 9'h066;
  localparam logic [8:0] SEG_5     = 9'h06D;
  localparam logic [8:0] SEG_6     = 9'h07D;
  localparam logic [8:0] SEG_7     = 9'h007;
  localparam logic [8:0] SEG_8     = 9'h07F;
  localparam logic [8:0] SEG_9     = 9'h06F;
  localparam logic [8:0] SEG_BLANK = 9'h000;

  function automatic logic [8:0] seg_of(input logic [3:0] digit);
    logic [8:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/decade_counter_ctrl_key_debounce.sv
// One push-button path: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on the accepted 1->0 transition of the level.
module key_debounce #(
  parameter int DEB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);
  import decade_counter_ctrl_pkg::*;

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          w_diff;
  logic          w_accept;

  // r_cnt holds how many consecutive samples already disagreed with r_level
  assign w_diff   = r_sync[1] ^ r_level;
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= w_accept & ~r_sync[1];
      if (!w_diff || w_accept) r_cnt <= '0;
      else                     r_cnt <= r_cnt + CW'(1);
      if (w_accept) r_level <= r_sync[1];
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/decade_counter_ctrl.sv
// Two-digit BCD event counter: debounced start/clear keys, run/pause/idle FSM,
// tick prescaler, wrapping up/down BCD count and a two-digit 7-segment scanner.
module decade_counter_ctrl #(
  parameter int TICK_DIV   = 12000000,
  parameter int DEB_CYCLES = 240000,
  parameter int SCAN_DIV   = 12000,
  parameter int MAX_COUNT  = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  input  logic       dir,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       running,
  output logic       carry,
  output logic [8:0] seg_led,
  output logic [1:0] seg_sel
);
  import decade_counter_ctrl_pkg::*;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    MAX_TENS  = 4'(MAX_COUNT / 10);
  localparam logic [3:0]    MAX_ONES  = 4'(MAX_COUNT % 10);

  logic [NUM_KEYS-1:0] w_key_n;
  logic [NUM_KEYS-1:0] w_press;
  logic                w_start;
  logic                w_clr;

  logic [1:0]    r_dir_sync;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [3:0]    r_ones;
  logic [3:0]    r_tens;
  logic [3:0]    w_ones_nxt;
  logic [3:0]    w_tens_nxt;
  logic          w_wrap;
  logic          r_running;
  logic          r_carry;
  logic [SW-1:0] r_scan;
  logic          w_scan_last;
  logic          w_sel_tens_nxt;
  logic [1:0]    r_sel;
  logic [8:0]    r_seg;

  assign w_key_n = {key_clear_n, key_start_n};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_key_n (w_key_n[g]),
      .o_press (w_press[g])
    );
  end

  assign w_start = w_press[KEY_START];
  assign w_clr   = w_press[KEY_CLEAR];

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_running  <= 1'b0;
      r_dir_sync <= 2'b11;
    end else begin
      r_state    <= w_state_nxt;
      r_running  <= (w_state_nxt == ST_RUN);
      r_dir_sync <= {r_dir_sync[0], dir};
    end
  end

  // Prescaler keeps its phase across PAUSE so resume does not restart the second
  assign w_tick = (r_state == ST_RUN) && (r_presc == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else begin
      case (r_state)
        ST_RUN:   r_presc <= w_tick ? '0 : r_presc + PW'(1);
        ST_PAUSE: r_presc <= r_presc;
        default:  r_presc <= '0;
      endcase
    end
  end

  always_comb begin
    w_ones_nxt = r_ones;
    w_tens_nxt = r_tens;
    w_wrap     = 1'b0;
    if (w_clr) begin
      w_ones_nxt = 4'd0;
      w_tens_nxt = 4'd0;
    end else if (w_tick) begin
      if (r_dir_sync[1]) begin
        if (r_tens == MAX_TENS && r_ones == MAX_ONES) begin
          w_ones_nxt = 4'd0;
          w_tens_nxt = 4'd0;
          w_wrap     = 1'b1;
        end else if (r_ones == 4'd9) begin
          w_ones_nxt = 4'd0;
          w_tens_nxt = r_tens + 4'd1;
        end else begin
          w_ones_nxt = r_ones + 4'd1;
        end
      end else begin
        if (r_tens == 4'd0 && r_ones == 4'd0) begin
          w_ones_nxt = MAX_ONES;
          w_tens_nxt = MAX_TENS;
          w_wrap     = 1'b1;
        end else if (r_ones == 4'd0) begin
          w_ones_nxt = 4'd9;
          w_tens_nxt = r_tens - 4'd1;
        end else begin
          w_ones_nxt = r_ones - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones  <= 4'd0;
      r_tens  <= 4'd0;
      r_carry <= 1'b0;
    end else begin
      r_ones  <= w_ones_nxt;
      r_tens  <= w_tens_nxt;
      r_carry <= w_wrap;
    end
  end

  // Segment data is built from the next count so seg_led never lags bcd_*
  assign w_scan_last    = (r_scan == SCAN_LAST);
  assign w_sel_tens_nxt = r_sel[0] ^ w_scan_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_sel  <= 2'b10;
      r_seg  <= SEG_0;
    end else begin
      r_scan <= w_scan_last ? '0 : r_scan + SW'(1);
      r_sel  <= {~w_sel_tens_nxt, w_sel_tens_nxt};
      if (w_sel_tens_nxt)
        r_seg <= (w_tens_nxt == 4'd0) ? SEG_BLANK : seg_of(w_tens_nxt);
      else
        r_seg <= seg_of(w_ones_nxt);
    end
  end

  assign bcd_ones = r_ones;
  assign bcd_tens = r_tens;
  assign running  = r_running;
  assign carry    = r_carry;
  assign seg_led  = r_seg;
  assign seg_sel  = r_sel;

endmodule

// File: tb/tb_decade_counter_ctrl.sv
// Bench for decade_counter_ctrl: integer-valued behavioural model compared every
// cycle, directed timing checks with literal expectations, then random key/dir traffic.
module tb_decade_counter_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 3;
  localparam int SCAN_DIV   = 2;
  localparam int MAX_COUNT  = 12;
  localparam logic [8:0] SEG_TAB [10] = '{9'h03F, 9'h006, 9'h05B, 9'h04F, 9'h066,
                                          9'h06D, 9'h07D, 9'h007, 9'h07F, 9'h06F};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic       dir = 1'b1;
  logic [3:0] bcd_ones;
  logic [3:0] bcd_tens;
  logic       running;
  logic       carry;
  logic [8:0] seg_led;
  logic [1:0] seg_sel;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  decade_counter_ctrl #(
    .TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES), .SCAN_DIV(SCAN_DIV), .MAX_COUNT(MAX_COUNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_start_n(key_start_n), .key_clear_n(key_clear_n),
    .dir(dir), .bcd_ones(bcd_ones), .bcd_tens(bcd_tens), .running(running),
    .carry(carry), .seg_led(seg_led), .seg_sel(seg_sel)
  );

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int bcd_val();
    return int'(bcd_tens) * 10 + int'(bcd_ones);
  endfunction

  // Model: state 0=idle 1=run 2=pause; count kept as a plain integer.
  int m_state, m_val, m_presc, m_cyc;
  bit m_carry;
  bit m_ks   [2][2];
  bit m_lvl  [2];
  bit m_prs  [2];
  bit m_hist [2][DEB_CYCLES];
  bit m_ds   [2];
  bit tick, smp, all_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_val = 0; m_presc = 0; m_cyc = 0; m_carry = 0;
      m_ds[0] = 1; m_ds[1] = 1;
      for (int k = 0; k < 2; k++) begin
        m_lvl[k] = 1; m_prs[k] = 0; m_ks[k][0] = 1; m_ks[k][1] = 1;
        for (int i = 0; i < DEB_CYCLES; i++) m_hist[k][i] = 1;
      end
    end else begin
      m_cyc++;
      tick = (m_state == 1) && (m_presc == TICK_DIV - 1);
      m_carry = 0;
      if (m_prs[1]) m_val = 0;
      else if (tick) begin
        if (m_ds[1]) begin
          if (m_val == MAX_COUNT) begin m_val = 0; m_carry = 1; end
          else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin m_val = MAX_COUNT; m_carry = 1; end
          else m_val = m_val - 1;
        end
      end
      if (m_state == 1) m_presc = (m_presc + 1) % TICK_DIV;
      else if (m_state == 0) m_presc = 0;
      if (m_prs[1]) m_state = 0;
      else if (m_prs[0]) m_state = (m_state == 1) ? 2 : 1;
      m_ds[1] = m_ds[0]; m_ds[0] = dir;
      for (int k = 0; k < 2; k++) begin
        smp = m_ks[k][1];
        m_ks[k][1] = m_ks[k][0];
        m_ks[k][0] = (k == 0) ? key_start_n : key_clear_n;
        for (int i = 0; i < DEB_CYCLES - 1; i++) m_hist[k][i] = m_hist[k][i+1];
        m_hist[k][DEB_CYCLES-1] = smp;
        all_diff = 1;
        for (int i = 0; i < DEB_CYCLES; i++) if (m_hist[k][i] == m_lvl[k]) all_diff = 0;
        m_prs[k] = 0;
        if (all_diff) begin m_lvl[k] = smp; m_prs[k] = (smp == 0); end
      end
    end
  end

  int  e_seg, e_sel;
  bit  e_tens;
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      e_tens = ((m_cyc / SCAN_DIV) % 2) == 1;
      e_sel  = e_tens ? 1 : 2;
      if (e_tens) e_seg = (m_val / 10 == 0) ? 0 : int'(SEG_TAB[m_val / 10]);
      else        e_seg = int'(SEG_TAB[m_val % 10]);
      cmp("m_ones",    int'(bcd_ones), m_val % 10);
      cmp("m_tens",    int'(bcd_tens), m_val / 10);
      cmp("m_running", int'(running),  int'(m_state == 1));
      cmp("m_carry",   int'(carry),    int'(m_carry));
      cmp("m_seg_sel", int'(seg_sel),  e_sel);
      cmp("m_seg_led", int'(seg_led),  e_seg);
    end
  end

  task automatic wait_bcd(input int v, input int lim);
    int n = 0;
    while (bcd_val() != v && n < lim) begin @(posedge clk); #1; n++; end
    cmp("wait_bcd", bcd_val(), v);
  endtask

  task automatic wait_running(input int lim);
    int n = 0;
    while (running !== 1'b1 && n < lim) begin @(posedge clk); #1; n++; end
    cmp("wait_running", int'(running), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    cmp({tag, "_bcd"},     bcd_val(),       0);
    cmp({tag, "_running"}, int'(running),   0);
    cmp({tag, "_carry"},   int'(carry),     0);
    cmp({tag, "_seg_sel"}, int'(seg_sel),   2);
    cmp({tag, "_seg_led"}, int'(seg_led),   'h03F);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("por");
    @(negedge clk) rst_n = 1'b1; chk_en = 1'b1;
    repeat (20) @(posedge clk);

    // 2-clock glitch, then a clean 10-clock press
    @(negedge clk) key_start_n = 1'b0;
    @(negedge clk);
    @(negedge clk) key_start_n = 1'b1;
    repeat (3) @(negedge clk);
    key_start_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 cmp("run_at_5", int'(running), 0);
    @(posedge clk);
    #1 cmp("run_at_6", int'(running), 1);
    repeat (4) @(posedge clk);
    #1 cmp("first_tick", bcd_val(), 1);
    @(negedge clk) key_start_n = 1'b1;

    // up-count wrap 11 -> 12 -> 00
    wait_bcd(11, 100);
    repeat (4) @(posedge clk);
    #1 cmp("up_12", bcd_val(), 12); cmp("up_12_carry", int'(carry), 0);
    repeat (4) @(posedge clk);
    #1 cmp("up_wrap", bcd_val(), 0); cmp("up_wrap_carry", int'(carry), 1);
    cmp("tens_blank", int'(seg_sel == 2'b01 ? seg_led : 9'h000), 0);

    // down-count wrap 00 -> 12 -> 11
    @(negedge clk) dir = 1'b0;
    @(posedge clk);
    #1 cmp("carry_one_cycle", int'(carry), 0);
    repeat (3) @(posedge clk);
    #1 cmp("dn_wrap", bcd_val(), 12); cmp("dn_wrap_carry", int'(carry), 1);
    repeat (4) @(posedge clk);
    #1 cmp("dn_11", bcd_val(), 11);

    // pause with prescaler at 2, hold, resume
    @(negedge clk) key_start_n = 1'b0;
    repeat (6) @(posedge clk);
    #1 cmp("paused", int'(running), 0); cmp("pause_val", bcd_val(), 10);
    @(negedge clk) key_start_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 cmp("frozen", bcd_val(), 10);
    @(negedge clk) key_start_n = 1'b0;
    wait_running(20);
    cmp("resume_val", bcd_val(), 10);
    @(negedge clk) key_start_n = 1'b1;
    @(posedge clk);
    #1 cmp("resume_p1", bcd_val(), 10);
    @(posedge clk);
    #1 cmp("resume_tick", bcd_val(), 9);

    // clear and start in the same cycle while running at 07
    wait_bcd(8, 20);
    @(negedge clk) key_start_n = 1'b0; key_clear_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 cmp("at_07", bcd_val(), 7); cmp("at_07_run", int'(running), 1);
    @(posedge clk);
    #1 cmp("clr_bcd", bcd_val(), 0); cmp("clr_run", int'(running), 0);
    cmp("clr_carry", int'(carry), 0);

    // clear lands on the first tick after start (down from 00 would wrap)
    @(negedge clk) key_start_n = 1'b1; key_clear_n = 1'b1;
    repeat (6) @(negedge clk);
    key_start_n = 1'b0;
    repeat (4) @(negedge clk);
    key_clear_n = 1'b0;
    wait_running(20);
    repeat (3) @(posedge clk);
    #1 cmp("pre_tick", bcd_val(), 0);
    @(posedge clk);
    #1 cmp("tickclr_bcd", bcd_val(), 0); cmp("tickclr_carry", int'(carry), 0);
    cmp("tickclr_run", int'(running), 0);

    // async reset mid-count and mid-debounce
    @(negedge clk) key_start_n = 1'b1; key_clear_n = 1'b1; dir = 1'b1;
    repeat (8) @(negedge clk);
    key_start_n = 1'b0;
    wait_running(20);
    repeat (4) @(posedge clk);
    #1 cmp("pre_rst", bcd_val(), 1);
    @(negedge clk) key_start_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // random key and direction traffic
    repeat (2000) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) key_start_n = ~key_start_n;
      if (key_clear_n ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0))
        key_clear_n = ~key_clear_n;
      if ($urandom_range(0, 39) == 0) dir = ~dir;
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
